// File: rtl/aixh_mxc_ltc_feeder_pkg.sv
// Shared types and constants for the MxConv left-column LTC feeder.
package AIXH_MXC_pkg;

  // Feeder control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } ltc_state_e;

  // Supported SRAM read latency range (clocks).
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Width of the command length field (beats minus one).
  localparam int LEN_W = 8;

  // In-flight beat counter width: worst case is RD_LAT_MAX pipeline stages
  // plus the output register, so it must hold RD_LAT_MAX + 1.
  localparam int INFL_W = $clog2(RD_LAT_MAX + 2);

endpackage

// File: rtl/aixh_mxc_ltc_vpipe.sv
// Shift pipeline carrying per-beat valid/last side information alongside
// the SRAM read latency. Cleared on reset so abandoned reads never surface.
module aixh_mxc_ltc_vpipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 6
) (
  input  logic             aixh_core_clk,
  input  logic             aixh_core_rst,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the side-band word one stage per clock.
  always_ff @(posedge aixh_core_clk or posedge aixh_core_rst) begin
    if (aixh_core_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/aixh_mxc_ltc_feeder.sv
// Strided multi-slice LTC SRAM reader feeding the MxConv left column.
// Accepts one command at a time, issues len+1 reads with a shared address,
// tracks them through the SRAM latency and registers the returned data.
module aixh_mxc_ltc_feeder
  import AIXH_MXC_pkg::*;
#(
  parameter int LTC_SLICES   = 4,
  parameter int SLICE_DWIDTH = 64,
  parameter int ADDR_WIDTH   = 10,
  parameter int RD_LATENCY   = 2
) (
  input  logic                                 aixh_core_clk,
  input  logic                                 aixh_core_rst,
  input  logic                                 i_cmd_vld,
  output logic                                 o_cmd_rdy,
  input  logic [ADDR_WIDTH-1:0]                i_cmd_base,
  input  logic [LEN_W-1:0]                     i_cmd_len,
  input  logic [ADDR_WIDTH-1:0]                i_cmd_stride,
  input  logic [LTC_SLICES-1:0]                i_cmd_mask,
  input  logic                                 i_hold,
  output logic [LTC_SLICES-1:0]                o_sram_ren,
  output logic [ADDR_WIDTH-1:0]                o_sram_addr,
  input  logic [LTC_SLICES*SLICE_DWIDTH-1:0]   i_sram_rdat,
  output logic [LTC_SLICES-1:0]                o_ltc_vld,
  output logic [LTC_SLICES*SLICE_DWIDTH-1:0]   o_ltc_dat,
  output logic                                 o_done
);

  localparam int DW = LTC_SLICES * SLICE_DWIDTH;
  // Side-band word: {last beat, beat issued, per-slice read enables}.
  localparam int PW = LTC_SLICES + 2;

  ltc_state_e            r_state;
  ltc_state_e            w_state_nxt;
  logic                  r_rdy_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [LEN_W-1:0]      r_cnt;
  logic [LEN_W-1:0]      r_len;
  logic [LTC_SLICES-1:0] r_mask;
  logic [INFL_W-1:0]     r_inflight;
  logic [INFL_W-1:0]     w_inflight_nxt;

  logic                  w_accept;
  logic                  w_issue;
  logic                  w_last_issue;
  logic [PW-1:0]         w_pipe_in;
  logic [PW-1:0]         w_pipe_out;

  logic [LTC_SLICES-1:0] r_ltc_vld;
  logic [DW-1:0]         r_ltc_dat;
  logic [DW-1:0]         w_ltc_dat_nxt;
  logic                  r_beat_out;
  logic                  r_done;

  // Ready is held low until the first clock after reset release.
  assign o_cmd_rdy    = r_rdy_en & (r_state == IDLE);
  assign w_accept     = i_cmd_vld & o_cmd_rdy;
  assign w_last_issue = w_issue & (r_cnt == r_len);
  assign o_sram_addr  = r_addr;

  // A beat leaves the in-flight set when the output register presents it.
  assign w_inflight_nxt = r_inflight + INFL_W'(w_issue) - INFL_W'(r_beat_out);

  // Next-state and issue decode; hold suspends issue without losing place.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    o_sram_ren  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!i_hold) begin
          w_issue    = 1'b1;
          o_sram_ren = r_mask;
          if (r_cnt == r_len) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_inflight_nxt == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus command capture, address walk and beat counting.
  always_ff @(posedge aixh_core_clk or posedge aixh_core_rst) begin
    if (aixh_core_rst) begin
      r_state    <= IDLE;
      r_rdy_en   <= 1'b0;
      r_addr     <= '0;
      r_stride   <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_mask     <= '0;
      r_inflight <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rdy_en   <= 1'b1;
      r_inflight <= w_inflight_nxt;
      if (w_accept) begin
        r_addr   <= i_cmd_base;
        r_stride <= i_cmd_stride;
        r_len    <= i_cmd_len;
        r_mask   <= i_cmd_mask;
        r_cnt    <= '0;
      end else if (w_issue) begin
        // Address wraps modulo the SRAM depth by natural overflow.
        r_addr <= r_addr + r_stride;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign w_pipe_in = {w_last_issue, w_issue, o_sram_ren};

  aixh_mxc_ltc_vpipe #(
    .DEPTH (RD_LATENCY),
    .WIDTH (PW)
  ) u_vpipe (
    .aixh_core_clk (aixh_core_clk),
    .aixh_core_rst (aixh_core_rst),
    .i_din         (w_pipe_in),
    .o_dout        (w_pipe_out)
  );

  // Slices that were not read present zero rather than stale SRAM data.
  for (genvar gi = 0; gi < LTC_SLICES; gi++) begin : g_slice
    assign w_ltc_dat_nxt[gi*SLICE_DWIDTH +: SLICE_DWIDTH] =
      w_pipe_out[gi] ? i_sram_rdat[gi*SLICE_DWIDTH +: SLICE_DWIDTH] : '0;
  end

  // Output register: one stage after the SRAM read data returns.
  always_ff @(posedge aixh_core_clk or posedge aixh_core_rst) begin
    if (aixh_core_rst) begin
      r_ltc_vld  <= '0;
      r_ltc_dat  <= '0;
      r_beat_out <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ltc_vld  <= w_pipe_out[LTC_SLICES-1:0];
      r_ltc_dat  <= w_ltc_dat_nxt;
      r_beat_out <= w_pipe_out[LTC_SLICES];
      r_done     <= w_pipe_out[LTC_SLICES+1];
    end
  end

  assign o_ltc_vld = r_ltc_vld;
  assign o_ltc_dat = r_ltc_dat;
  assign o_done    = r_done;

endmodule
